regfile_write_buffer: RTL

//  Write-side front end of the Registradores bank. It accepts writeback requests from two producers,
//  the ALU and the load unit, over valid/ready. It queues them in an in-order FIFO and drains one entry
//  per cycle onto the bank's single write port (RegWrite/WriteRegister/WriteData).
//  It also bypasses queued, not-yet-written values to the operand readers.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wb_bypass_lookup.sv | 32 +++
 rtl/regfile_write_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-bank write path.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_bypass_lookup.sv
// Combinational lookup of the youngest queued entry matching a read index.
module wb_bypass_lookup
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PW-1:0]         head,
  input  logic [CW-1:0]         count,
  input  logic [ADDR_W-1:0]     index,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PW-1:0] slot;
    hit  = 1'b0;
    data = '0;
    slot = head;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if ((CW'(k) < count) && (index != REG_ZERO) && (entries[slot].reg_idx == index)) begin
        hit  = 1'b1;
        data = entries[slot].data;
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order writeback queue merging load and ALU results onto one register-bank write port.
module regfile_write_buffer
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemValid,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemReady,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              Hold,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              Hit1,
  output logic              Hit2,
  output logic [DATA_W-1:0] Bypass1,
  output logic [DATA_W-1:0] Bypass2,
  output logic [CW-1:0]     Count,
  output logic              Full,
  output logic              Empty
);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, free;
  logic mem_push, alu_push, pop;

  // Credit comes only from the start-of-cycle occupancy; a same-cycle pop frees nothing.
  assign free     = CW'(DEPTH) - count_q;
  assign MemReady = (free >= CW'(1));
  assign AluReady = (free >= CW'(2)) | ((free == CW'(1)) & !MemValid);

  // r0 requests complete the handshake but never occupy a slot.
  assign mem_push = MemValid & MemReady & (MemReg != REG_ZERO);
  assign alu_push = AluValid & AluReady & (AluReg != REG_ZERO);

  assign Empty         = (count_q == '0);
  assign Full          = (count_q == CW'(DEPTH));
  assign Count         = count_q;
  assign pop           = !Empty & !Hold;
  assign RegWrite      = pop;
  assign WriteRegister = Empty ? REG_ZERO : entries_q[rd_ptr_q].reg_idx;
  assign WriteData     = Empty ? '0 : entries_q[rd_ptr_q].data;

  // Load is the older instruction, so it takes the first free slot.
  always_comb begin
    entries_d = entries_q;
    if (mem_push) entries_d[wr_ptr_q] = '{reg_idx: MemReg, data: MemData};
    if (alu_push) entries_d[wr_ptr_q + PW'(mem_push)] = '{reg_idx: AluReg, data: AluData};
    wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (int'(count_q) + int'(mem_push) + int'(alu_push) - int'(pop) <= DEPTH);
  end

  logic [1:0][ADDR_W-1:0] rd_idx;
  logic [1:0]             rd_hit;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_idx = {ReadRegister2, ReadRegister1};

  for (genvar p = 0; p < 2; p++) begin : g_byp
    wb_bypass_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries (entries_q),
      .head    (rd_ptr_q),
      .count   (count_q),
      .index   (rd_idx[p]),
      .hit     (rd_hit[p]),
      .data    (rd_data[p])
    );
  end

  assign Hit1    = rd_hit[0];
  assign Hit2    = rd_hit[1];
  assign Bypass1 = rd_data[0];
  assign Bypass2 = rd_data[1];

endmodule
